// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes, select constants and control word for multicycle_ctl
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXE   = 4'd7,
    S_RWB    = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_IEXE   = 4'd11,
    S_IWB    = 4'd12
  } state_e;

  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;
  localparam logic [5:0] OPC_BEQ  = 6'h04;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_ADDI = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Moore control word; irwrite/pcwrite in FETCH and done in MEMWR are
  // qualified by mem_ready in the top level.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - state to control-word decoder; IEXE/IWB decode only when MC_ADDI_EN is defined
module mc_outdec
  import mc_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // One control word per state; anything not set stays 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memread  = 1'b1;
        ctrl_o.irwrite  = 1'b1;
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.alusrcb  = SRCB_FOUR;
        ctrl_o.aluop    = ALU_ADD;
        ctrl_o.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMM_SH;
        ctrl_o.aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.done     = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.done     = 1'b1;
      end
      S_REXE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
        ctrl_o.done     = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.alusrcb     = SRCB_B;
        ctrl_o.aluop       = ALU_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
        ctrl_o.done        = 1'b1;
      end
      S_JMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
        ctrl_o.done     = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_IEXE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALU_ADD;
      end
      S_IWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.done     = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctl.sv
// rtl/multicycle_ctl.sv - multi-cycle MIPS control FSM; MC_ADDI_EN enables addi (opcode 0x08)
module multicycle_ctl
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUsrcA,
  output logic [1:0]         ALUsrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  localparam logic [OP_W-1:0] OP_R_W    = OP_W'(OPC_R);
  localparam logic [OP_W-1:0] OP_LW_W   = OP_W'(OPC_LW);
  localparam logic [OP_W-1:0] OP_SW_W   = OP_W'(OPC_SW);
  localparam logic [OP_W-1:0] OP_BEQ_W  = OP_W'(OPC_BEQ);
  localparam logic [OP_W-1:0] OP_J_W    = OP_W'(OPC_J);
`ifdef MC_ADDI_EN
  localparam logic [OP_W-1:0] OP_ADDI_W = OP_W'(OPC_ADDI);
`endif

  state_e state_q, state_d;
  // MEMADR must pick MEMRD vs MEMWR after OP has stopped being sampled.
  logic   is_lw_q, is_lw_d;
  logic   illegal;
  ctrl_t  ctrl;

  mc_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // State and load/store flag registers; reset parks the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_lw_q <= is_lw_d;
    end
  end

  // Next-state logic; unreachable encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    is_lw_d = is_lw_q;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_lw_d = (OP == OP_LW_W);
        if (OP == OP_LW_W || OP == OP_SW_W) state_d = S_MEMADR;
        else if (OP == OP_R_W)              state_d = S_REXE;
        else if (OP == OP_BEQ_W)            state_d = S_BEQ;
        else if (OP == OP_J_W)              state_d = S_JMP;
`ifdef MC_ADDI_EN
        else if (OP == OP_ADDI_W)           state_d = S_IEXE;
`endif
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXE:   state_d = S_RWB;
      S_MEMWB, S_RWB, S_BEQ, S_JMP: state_d = S_FETCH;
`ifdef MC_ADDI_EN
      S_IEXE:   state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Drive outputs; only the FETCH writes and the MEMWR done pulse wait on mem_ready.
  always_comb begin
    PCWrite     = ctrl.pcwrite & ~((state_q == S_FETCH) & ~mem_ready);
    IRWrite     = ctrl.irwrite & mem_ready;
    instr_done  = ctrl.done & ~((state_q == S_MEMWR) & ~mem_ready);
    PCWriteCond = ctrl.pcwritecond;
    IorD        = ctrl.iord;
    MemRead     = ctrl.memread;
    MemWrite    = ctrl.memwrite;
    MemtoReg    = ctrl.memtoreg;
    RegWrite    = ctrl.regwrite;
    RegDst      = ctrl.regdst;
    ALUsrcA     = ctrl.alusrca;
    ALUsrcB     = ctrl.alusrcb;
    PCSource    = ctrl.pcsource;
    ALUop       = ALUOP_W'(ctrl.aluop);
    illegal_op  = illegal;
    state       = state_q;
  end

endmodule

// File: tb/tb_multicycle_ctl.sv
// tb/tb_multicycle_ctl.sv - scoreboard bench for multicycle_ctl
module tb_multicycle_ctl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OP;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUsrcA, instr_done, illegal_op;
  logic [1:0] ALUsrcB, PCSource, ALUop;
  logic [3:0] state;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;
  exp_t sb_q[$];

  multicycle_ctl #(.OP_W(6), .ALUOP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .PCSource(PCSource),
    .ALUop(ALUop), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  wire [17:0] act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegWrite, RegDst, ALUsrcA, ALUsrcB, PCSource,
                     ALUop, instr_done, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_ctrl(input state_e st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, dn, il, legal;
    logic [1:0] sb, ps, ao;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, dn, il} = '0;
    sb = 2'd0; ps = 2'd0; ao = 2'd0;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef MC_ADDI_EN
    legal = legal || (op == 6'h08);
`endif
    case (st)
      S_FETCH:  begin mrd = 1; sb = 2'd1; irw = mr; pcw = mr; end
      S_DECODE: begin sb = 2'd3; il = ~legal; end
      S_MEMADR: begin sa = 1; sb = 2'd2; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; dn = mr; end
      S_REXE:   begin sa = 1; ao = 2'd2; end
      S_RWB:    begin rw = 1; rd = 1; dn = 1; end
      S_BEQ:    begin sa = 1; ao = 2'd1; pcwc = 1; ps = 2'd1; dn = 1; end
      S_JMP:    begin pcw = 1; ps = 2'd2; dn = 1; end
      S_IEXE:   begin sa = 1; sb = 2'd2; end
      S_IWB:    begin rw = 1; dn = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, sa, sb, ps, ao, dn, il};
  endfunction

  // Called at posedge+1: drive inputs, push the expectation, compare mid-cycle.
  task automatic cyc(input string tag, input logic [5:0] op, input logic mr, input state_e st);
    exp_t e;
    OP = op;
    mem_ready = mr;
    sb_q.push_back('{st: st, ctl: exp_ctrl(st, mr, op)});
    #3;
    if (sb_q.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_st"}, {28'd0, state}, {28'd0, e.st});
      check({tag, "_ctl"}, {14'd0, act}, {14'd0, e.ctl});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    OP = 6'h00;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst", 6'h00, 1'b1, S_IDLE);
    cyc("rst", 6'h00, 1'b1, S_IDLE);
    rst_n = 1'b1;
    cyc("rel", 6'h23, 1'b1, S_IDLE);

    // lw: 5 cycles
    cyc("lw", 6'h23, 1'b1, S_FETCH);
    cyc("lw", 6'h23, 1'b1, S_DECODE);
    cyc("lw", 6'h23, 1'b1, S_MEMADR);
    cyc("lw", 6'h23, 1'b1, S_MEMRD);
    cyc("lw", 6'h23, 1'b1, S_MEMWB);

    // sw with 3 stall cycles in MEMWR: 7 cycles
    cyc("sw", 6'h2B, 1'b1, S_FETCH);
    cyc("sw", 6'h2B, 1'b0, S_DECODE);
    cyc("sw", 6'h2B, 1'b0, S_MEMADR);
    for (int i = 0; i < 3; i++) cyc("sw_stall", 6'h2B, 1'b0, S_MEMWR);
    cyc("sw", 6'h2B, 1'b1, S_MEMWR);

    // beq and j: 3 cycles each
    cyc("beq", 6'h04, 1'b1, S_FETCH);
    cyc("beq", 6'h04, 1'b1, S_DECODE);
    cyc("beq", 6'h04, 1'b0, S_BEQ);
    cyc("j", 6'h02, 1'b1, S_FETCH);
    cyc("j", 6'h02, 1'b1, S_DECODE);
    cyc("j", 6'h02, 1'b1, S_JMP);

    // R-type with a two-cycle fetch stall
    cyc("r_fstall", 6'h00, 1'b0, S_FETCH);
    cyc("r_fstall", 6'h00, 1'b0, S_FETCH);
    cyc("r", 6'h00, 1'b1, S_FETCH);
    cyc("r", 6'h00, 1'b1, S_DECODE);
    cyc("r", 6'h00, 1'b1, S_REXE);
    cyc("r", 6'h00, 1'b1, S_RWB);

    // illegal opcode
    cyc("ill", 6'h3F, 1'b1, S_FETCH);
    cyc("ill", 6'h3F, 1'b1, S_DECODE);

    // addi: legal only with MC_ADDI_EN
    cyc("addi", 6'h08, 1'b1, S_FETCH);
    cyc("addi", 6'h08, 1'b1, S_DECODE);
`ifdef MC_ADDI_EN
    cyc("addi", 6'h08, 1'b1, S_IEXE);
    cyc("addi", 6'h08, 1'b1, S_IWB);
`endif

    // lw with reset asserted while stalled in MEMRD
    cyc("lwr", 6'h23, 1'b1, S_FETCH);
    cyc("lwr", 6'h23, 1'b1, S_DECODE);
    cyc("lwr", 6'h23, 1'b1, S_MEMADR);
    cyc("lwr", 6'h23, 1'b0, S_MEMRD);
    rst_n = 1'b0;
    #1;
    check("async_rst_st", {28'd0, state}, {28'd0, S_IDLE});
    check("async_rst_ctl", {14'd0, act}, 32'd0);
    @(posedge clk);
    #1;
    cyc("rst2", 6'h23, 1'b1, S_IDLE);
    rst_n = 1'b1;
    cyc("rel2", 6'h00, 1'b1, S_IDLE);
    cyc("rel2", 6'h00, 1'b1, S_FETCH);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctl.md
# multicycle_ctl

Multi-cycle CPU control unit: a Moore state machine that sequences each MIPS instruction through fetch, decode, execute, memory and write-back, one step per clock. It sits between the instruction register's opcode field and the shared datapath (single ALU, single memory port, PC/IR/A/B/ALUOut registers). It generalises the single-cycle control decode with parametrised opcode/ALUop widths, a memory-ready stall handshake, illegal-opcode reporting and optional `addi`.

## Interface
- `OP_W`, 6: opcode width; decoded opcodes are zero-extended constants.
- `ALUOP_W`, 2: ALUop width; must be at least 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `OP`  in  OP_W  opcode from IR; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUsrcA`  out  1  datapath controls.
- `ALUsrcB`  out  2  0=B, 1=constant 4, 2=sign-extended imm, 3=imm<<2.
- `PCSource`  out  2  0=ALU, 1=ALUOut, 2=jump target.
- `ALUop`  out  ALUOP_W  0=add, 1=sub, 2=funct field.
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08 (macro-gated).
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXE, RWB, BEQ, JMP, IEXE, IWB.
- IDLE: entered by reset; all outputs 0; moves to FETCH on the first clock after release.
- FETCH: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=1, ALUop=add, PCSource=0. Holds while mem_ready=0. IRWrite and PCWrite are asserted only in the cycle where mem_ready=1 (the only Mealy outputs); that cycle advances to DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=3, ALUop=add. Branches on OP:
  - lw/sw → MEMADR; R → REXE; beq → BEQ; j → JMP; addi → IEXE.
  - Any other opcode → FETCH, with illegal_op=1.
- MEMADR: ALUsrcA=1, ALUsrcB=2, add; lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1; holds until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done → FETCH.
- MEMWR: MemWrite=1, IorD=1; holds until mem_ready. instr_done pulses in the mem_ready cycle, then → FETCH.
- REXE: ALUsrcA=1, ALUsrcB=0, ALUop=funct → RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done → FETCH.
- BEQ: ALUsrcA=1, ALUsrcB=0, sub, PCWriteCond=1, PCSource=1, instr_done → FETCH.
- JMP: PCWrite=1, PCSource=2, instr_done → FETCH.
- IEXE: ALUsrcA=1, ALUsrcB=2, add → IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done → FETCH.
- Any output not listed for a state is 0 in that state.
- An unreachable `state` encoding recovers to FETCH on the next clock.

## Timing
- With mem_ready held high, each instruction takes, from FETCH entry to its instr_done cycle:
  - lw 5 cycles; R, sw and addi 4 cycles; beq and j 3 cycles.
- Each stalled cycle (mem_ready=0 in FETCH/MEMRD/MEMWR) adds exactly one cycle; outputs stay constant during a stall.
- Reset mid-instruction: state goes to IDLE immediately (asynchronously) and outputs go to 0 with no clock; a pending memory access is abandoned.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.

## Configuration
- `MC_ADDI_EN` defined: opcode 0x08 decodes to IEXE → IWB.
- `MC_ADDI_EN` undefined:
  - 0x08 is illegal (illegal_op pulse, return to FETCH).
  - IEXE and IWB are not generated; their encodings count as unreachable.

## Structure
- Shared package `mc_pkg`: state enum (4-bit), opcode constants, ALUop constants (ALU_ADD, ALU_SUB, ALU_FUNCT), ALUsrcB and PCSource select constants.
- One sub-module, `mc_outdec`: purely combinational state → control-word decoder.
- The top level holds the state register, next-state logic and the mem_ready gating of IRWrite/PCWrite.

## Test plan
- Reset, then release with mem_ready=1:
  - During reset, all outputs 0 and state=IDLE.
  - Cycle 1 after release: FETCH, with MemRead=1, IRWrite=1, PCWrite=1.
- lw (OP=0x23), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; instr_done only in cycle 5, with RegWrite=1 and MemtoReg=1.
- sw, with mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 cycles; instr_done coincides with mem_ready=1; total 7 cycles.
- beq then j → 3 cycles each:
  - beq: PCWriteCond=1, ALUop=1 in BEQ.
  - j: PCWrite=1, PCSource=2 in JMP.
- OP=0x3F → illegal_op pulse in DECODE, next state FETCH, no RegWrite/MemWrite. Repeat with OP=0x08 under each setting of MC_ADDI_EN.
- rst_n asserted low in MEMRD → outputs drop to 0 before the next edge; after release the next state is FETCH.
